fifo_ctrl_machine: RTL and testbench
====================================

# fifo_ctrl_machine

Parametrised top-level control FSM for the multi-channel FIFO datapath. It sequences the datapath through reset, configuration, idle and active phases. It latches per-channel low/high threshold limits during configuration and declares idle only after all channels have been empty for a programmable number of cycles. It also traps per-channel FIFO errors into a sticky ERROR state that holds the datapath in reset until reconfiguration.

## Interface
- NCH, 4, number of FIFO channels (≥1)
- LIM_W, 3, width of each threshold limit
- IDLE_DLY, 4, consecutive all-empty cycles required for ACTIVE→IDLE (≥1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- init  in  1  configuration request; high = stay in/enter INIT and capture limits
- emptys  in  NCH  per-channel FIFO empty flags
- error  in  NCH  per-channel FIFO error pulses (overflow/underflow)
- limit_low  in  NCH*LIM_W  per-channel low thresholds, channel i at [i*LIM_W +: LIM_W]
- limit_high  in  NCH*LIM_W  per-channel high thresholds, same packing
- limit_low_out  out  NCH*LIM_W  latched low thresholds
- limit_high_out  out  NCH*LIM_W  latched high thresholds
- reset_out  out  1  active-low datapath reset
- idle_out  out  1  high in IDLE
- active_out  out  1  high in ACTIVE
- error_out  out  1  high in ERROR
- err_chan  out  NCH  sticky record of channels that raised error
- cfg_err  out  NCH  per-channel invalid-limit flag (see Configuration)

## Operation
- States, one-hot: RESET, INIT, IDLE, ACTIVE, ERROR.
- Transition priority: reset low > init > error > emptys.
- Any state, reset=0 → RESET. All registers take reset values.
- RESET → INIT when reset=1.
- INIT: init=1 → INIT; init=0 → IDLE. error is ignored in INIT.
- IDLE: init=1 → INIT; |error → ERROR; any emptys bit low → ACTIVE; else stay.
- ACTIVE: init=1 → INIT; |error → ERROR.
  - Idle counter increments while &emptys and clears otherwise.
  - → IDLE when &emptys and counter == IDLE_DLY-1. Counter clears on leaving ACTIVE.
- ERROR: init=1 → INIT; otherwise stay. Emptys are ignored.
- err_chan: ORs in error bits sampled in IDLE/ACTIVE/ERROR. Clears in RESET and on every cycle in INIT.
- Limits: each cycle with reset=1 and init=1, limit_*_out load the inputs (any state). Otherwise they hold.
- Outputs are decoded from state:
  - RESET: reset_out=0, all flags 0.
  - INIT: reset_out=~init, all flags 0.
  - IDLE: reset_out=1, idle_out=1.
  - ACTIVE: reset_out=1, active_out=1.
  - ERROR: reset_out=0, error_out=1.
- Exactly one of idle_out/active_out/error_out is high, or none.

## Timing
- Reset values: state RESET, reset_out=0, idle_out=active_out=error_out=0, err_chan=0, cfg_err=0, limit_low_out=0, limit_high_out=all ones. Idle counter=0.
- Reset takes effect on the first rising edge with reset=0. Release reaches INIT one cycle later.
- State changes one cycle after the sampled cause. Flags follow state in the same cycle.
- reset_out in INIT is combinational from init (zero-cycle).
- Limits are visible one cycle after init is sampled high.
- Minimum ACTIVE→IDLE latency is IDLE_DLY cycles of continuous &emptys. Any non-empty cycle restarts the count.
- When init and error are both high in the same cycle, the FSM goes to INIT and err_chan clears.

## Configuration
- LIMIT_CHECK_EN defined: on each capture, channel i loads only if low_i ≤ high_i.
  - An invalid channel keeps its previous limits and sets cfg_err[i].
  - cfg_err[i] clears on the next valid capture of that channel, or on reset.
- LIMIT_CHECK_EN undefined: all channels load unconditionally and cfg_err is tied to 0.

## Test plan
All scenarios use NCH=4, LIM_W=3, IDLE_DLY=4.
- Reset, then release with init=1 for 3 cycles, then init=0 → RESET, INIT×3, IDLE. reset_out goes 0→1 in the cycle init falls.
- In IDLE, emptys=4'b1011 for 2 cycles, then 4'b1111 → ACTIVE next cycle. Stays ACTIVE for exactly 4 all-empty cycles, then IDLE. A single 4'b1110 glitch at count 2 restarts the count.
- init=1 with limit_low=12'h111, limit_high=12'h666 → outputs 12'h111/12'h666 one cycle later, and they hold after init falls.
- In ACTIVE, pulse error=4'b0100 → ERROR, err_chan=4'b0100, reset_out=0. Then error=4'b0001 → err_chan=4'b0101. init=1 → INIT, err_chan=0.
- reset=0 mid-ACTIVE → RESET next cycle, with limits back to 0 and all ones.
- With LIMIT_CHECK_EN, capture ch1 low=5, high=2 → ch1 limits unchanged, cfg_err=4'b0010. Other channels load. Without the macro, values load and cfg_err=0.

Source files
------------

// File: rtl/fifo_ctrl_machine_if.sv
// Control/status bundle between the FIFO control FSM (master) and the datapath (slave).
interface fifo_ctrl_machine_if #(
    parameter int NCH   = 4,
    parameter int LIM_W = 3
);
    logic                   init;
    logic [NCH-1:0]         emptys;
    logic [NCH-1:0]         error;
    logic [NCH*LIM_W-1:0]   limit_low;
    logic [NCH*LIM_W-1:0]   limit_high;
    logic [NCH*LIM_W-1:0]   limit_low_out;
    logic [NCH*LIM_W-1:0]   limit_high_out;
    logic                   reset_out;
    logic                   idle_out;
    logic                   active_out;
    logic                   error_out;
    logic [NCH-1:0]         err_chan;
    logic [NCH-1:0]         cfg_err;

    modport master (
        input  init, emptys, error, limit_low, limit_high,
        output limit_low_out, limit_high_out, reset_out, idle_out,
               active_out, error_out, err_chan, cfg_err
    );

    modport slave (
        output init, emptys, error, limit_low, limit_high,
        input  limit_low_out, limit_high_out, reset_out, idle_out,
               active_out, error_out, err_chan, cfg_err
    );
endinterface

// File: rtl/fifo_ctrl_machine.sv
// Top-level control FSM for the multi-channel FIFO datapath (RESET/INIT/IDLE/ACTIVE/ERROR).
// Optional macro LIMIT_CHECK_EN: reject captured limits where low > high and flag cfg_err.
module fifo_ctrl_machine #(
    parameter int NCH      = 4,
    parameter int LIM_W    = 3,
    parameter int IDLE_DLY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_ctrl_machine_if.master  bus
);
    localparam int CNT_W = (IDLE_DLY > 1) ? $clog2(IDLE_DLY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_idle_cnt_next;
    logic [NCH-1:0]   r_err_chan;
    logic [NCH-1:0]   w_err_chan_next;
    logic             w_all_empty;
    logic             w_any_err;

    assign w_all_empty = &bus.emptys;
    assign w_any_err   = |bus.error;

    // Active-low reset is handled in the register process; this logic assumes reset=1.
    always_comb begin
        w_state_next    = r_state;
        w_idle_cnt_next = '0;
        case (r_state)
            ST_RESET:  w_state_next = ST_INIT;
            ST_INIT:   if (!bus.init) w_state_next = ST_IDLE;
            ST_IDLE: begin
                if (bus.init)          w_state_next = ST_INIT;
                else if (w_any_err)    w_state_next = ST_ERROR;
                else if (!w_all_empty) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.init)       w_state_next = ST_INIT;
                else if (w_any_err) w_state_next = ST_ERROR;
                else if (w_all_empty) begin
                    if (r_idle_cnt == CNT_LAST) w_state_next = ST_IDLE;
                    else                        w_idle_cnt_next = r_idle_cnt + 1'b1;
                end
            end
            ST_ERROR:  if (bus.init) w_state_next = ST_INIT;
            default:   w_state_next = ST_RESET;
        endcase
    end

    // Clearing on the way into INIT lets a simultaneous init+error leave no trace.
    always_comb begin
        w_err_chan_next = r_err_chan;
        if (w_state_next == ST_INIT || w_state_next == ST_RESET)
            w_err_chan_next = '0;
        else if (r_state == ST_IDLE || r_state == ST_ACTIVE || r_state == ST_ERROR)
            w_err_chan_next = r_err_chan | bus.error;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RESET;
            r_idle_cnt <= '0;
            r_err_chan <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idle_cnt <= w_idle_cnt_next;
            r_err_chan <= w_err_chan_next;
        end
    end

    always_comb begin
        bus.reset_out  = 1'b0;
        bus.idle_out   = 1'b0;
        bus.active_out = 1'b0;
        bus.error_out  = 1'b0;
        case (r_state)
            ST_INIT:   bus.reset_out = ~bus.init;
            ST_IDLE:   begin bus.reset_out = 1'b1; bus.idle_out   = 1'b1; end
            ST_ACTIVE: begin bus.reset_out = 1'b1; bus.active_out = 1'b1; end
            ST_ERROR:  bus.error_out = 1'b1;
            default:   bus.reset_out = 1'b0;
        endcase
    end

    assign bus.err_chan = r_err_chan;

    logic [LIM_W-1:0]     r_lim_low  [NCH];
    logic [LIM_W-1:0]     r_lim_high [NCH];
    logic [NCH-1:0]       w_cfg_err;
    logic [NCH*LIM_W-1:0] w_low_packed;
    logic [NCH*LIM_W-1:0] w_high_packed;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [LIM_W-1:0] w_low_in;
            logic [LIM_W-1:0] w_high_in;
            logic             w_load;

            assign w_low_in  = bus.limit_low[gi*LIM_W +: LIM_W];
            assign w_high_in = bus.limit_high[gi*LIM_W +: LIM_W];
`ifdef LIMIT_CHECK_EN
            logic r_cfg_err;

            assign w_load = bus.init && (w_low_in <= w_high_in);

            always_ff @(posedge clk) begin
                if (!reset)        r_cfg_err <= 1'b0;
                else if (bus.init) r_cfg_err <= ~w_load;
            end
            assign w_cfg_err[gi] = r_cfg_err;
`else
            assign w_load        = bus.init;
            assign w_cfg_err[gi] = 1'b0;
`endif
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_lim_low[gi]  <= '0;
                    r_lim_high[gi] <= '1;
                end else if (w_load) begin
                    r_lim_low[gi]  <= w_low_in;
                    r_lim_high[gi] <= w_high_in;
                end
            end
        end
    endgenerate

    always_comb begin
        w_low_packed  = '0;
        w_high_packed = '0;
        for (int i = 0; i < NCH; i++) begin
            w_low_packed[i*LIM_W +: LIM_W]  = r_lim_low[i];
            w_high_packed[i*LIM_W +: LIM_W] = r_lim_high[i];
        end
    end

    assign bus.limit_low_out  = w_low_packed;
    assign bus.limit_high_out = w_high_packed;
    assign bus.cfg_err        = w_cfg_err;
endmodule

// File: tb/tb_fifo_ctrl_machine.sv
// Directed table-driven bench for fifo_ctrl_machine (NCH=4, LIM_W=3, IDLE_DLY=4).
module tb_fifo_ctrl_machine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_ctrl_machine_if #(.NCH(4), .LIM_W(3)) bus ();
    fifo_ctrl_machine #(.NCH(4), .LIM_W(3), .IDLE_DLY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        r;
        logic        i;
        logic [3:0]  e;
        logic [3:0]  er;
        logic [11:0] ll;
        logic [11:0] lh;
        logic [3:0]  xf;   // {reset_out, idle_out, active_out, error_out}
        logic [3:0]  xec;
        logic [3:0]  xce;
        logic [11:0] xlo;
        logic [11:0] xhi;
    } vec_t;

    vec_t        vecs[$];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] m_lo  = 12'h000;
    logic [11:0] m_hi  = 12'hFFF;
    logic [3:0]  m_ce  = 4'h0;

    function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    // Limit/cfg_err expectations come from a per-channel capture model.
    task automatic add(input logic r, input logic i, input logic [3:0] e, input logic [3:0] er,
                       input logic [11:0] ll, input logic [11:0] lh,
                       input logic [3:0] xf, input logic [3:0] xec);
        vec_t v;
        if (!r) begin
            m_lo = 12'h000; m_hi = 12'hFFF; m_ce = 4'h0;
        end else if (i) begin
            for (int c = 0; c < 4; c++) begin
                logic ok;
`ifdef LIMIT_CHECK_EN
                ok = (ll[c*3 +: 3] <= lh[c*3 +: 3]);
`else
                ok = 1'b1;
`endif
                if (ok) begin
                    m_lo[c*3 +: 3] = ll[c*3 +: 3];
                    m_hi[c*3 +: 3] = lh[c*3 +: 3];
                    m_ce[c] = 1'b0;
                end else begin
                    m_ce[c] = 1'b1;
                end
            end
        end
        v = '{r, i, e, er, ll, lh, xf, xec, m_ce, m_lo, m_hi};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] a_lo, a_hi, b_lo;
        logic [3:0]  flags;
        a_lo = pk(3, 1, 1, 0);
        a_hi = pk(7, 4, 2, 6);
        b_lo = pk(3, 1, 5, 0);

        // r  i  emptys   error    limit_low  limit_high  flags    err_chan
        add(0, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b0000, 4'h0);
        add(0, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b0000, 4'h0);
        add(1, 1, 4'hF,    4'h0,    12'h111,   12'h666,    4'b0000, 4'h0);
        add(1, 1, 4'hF,    4'hF,    12'h111,   12'h666,    4'b0000, 4'h0);
        add(1, 1, 4'hF,    4'h0,    12'h111,   12'h666,    4'b0000, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);
        add(1, 0, 4'b1011, 4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'b1011, 4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);
        add(1, 0, 4'b1110, 4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'b1110, 4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);
        add(1, 0, 4'b1110, 4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(1, 0, 4'hF,    4'b0100, 12'h000,   12'h000,    4'b0001, 4'b0100);
        add(1, 0, 4'hF,    4'b0001, 12'h000,   12'h000,    4'b0001, 4'b0101);
        add(1, 0, 4'h0,    4'h0,    12'h000,   12'h000,    4'b0001, 4'b0101);
        add(1, 1, 4'hF,    4'b0010, pk(2,0,1,0), pk(7,5,6,0), 4'b0000, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);
        add(1, 0, 4'b0111, 4'h0,    12'h000,   12'h000,    4'b1010, 4'h0);
        add(0, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b0000, 4'h0);
        add(1, 1, 4'hF,    4'h0,    a_lo,      a_hi,       4'b0000, 4'h0);
        add(1, 1, 4'hF,    4'h0,    b_lo,      a_hi,       4'b0000, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);
        add(1, 0, 4'hF,    4'b1000, 12'h000,   12'h000,    4'b0001, 4'b1000);
        add(1, 1, 4'hF,    4'b0001, a_lo,      a_hi,       4'b0000, 4'h0);
        add(1, 0, 4'hF,    4'h0,    12'h000,   12'h000,    4'b1100, 4'h0);

        reset = 1'b0; bus.init = 1'b0; bus.emptys = 4'hF; bus.error = 4'h0;
        bus.limit_low = 12'h000; bus.limit_high = 12'h000;

        for (int k = 0; k < vecs.size(); k++) begin
            reset          = vecs[k].r;
            bus.init       = vecs[k].i;
            bus.emptys     = vecs[k].e;
            bus.error      = vecs[k].er;
            bus.limit_low  = vecs[k].ll;
            bus.limit_high = vecs[k].lh;
            step();
            flags = {bus.reset_out, bus.idle_out, bus.active_out, bus.error_out};
            chk("flags",    k, 32'(flags),              32'(vecs[k].xf));
            chk("err_chan", k, 32'(bus.err_chan),       32'(vecs[k].xec));
            chk("cfg_err",  k, 32'(bus.cfg_err),        32'(vecs[k].xce));
            chk("lim_low",  k, 32'(bus.limit_low_out),  32'(vecs[k].xlo));
            chk("lim_high", k, 32'(bus.limit_high_out), 32'(vecs[k].xhi));
            $display("vec %0d: r=%0b i=%0b e=%b er=%b -> flags=%b ec=%b ce=%b lo=%h hi=%h",
                     k, vecs[k].r, vecs[k].i, vecs[k].e, vecs[k].er, flags,
                     bus.err_chan, bus.cfg_err, bus.limit_low_out, bus.limit_high_out);
        end

        // reset_out in INIT follows init combinationally, before the next edge.
        bus.init = 1'b1; bus.error = 4'h0; bus.limit_low = a_lo; bus.limit_high = a_hi;
        step();
        chk("init_rst_out_hi_init", 100, 32'(bus.reset_out), 32'd0);
        bus.init = 1'b0;
        #1;
        chk("init_rst_out_comb", 101, 32'(bus.reset_out), 32'd1);
        chk("init_not_idle_yet", 102, 32'(bus.idle_out), 32'd0);
        step();
        chk("idle_after_init", 103, 32'(bus.idle_out), 32'd1);
        $display("seq comb: reset_out follows init in INIT, idle next edge");

        // Channel 1 capture with low > high.
        bus.init = 1'b1; bus.limit_low = a_lo; bus.limit_high = a_hi;
        step();
        bus.limit_low = b_lo;
        step();
`ifdef LIMIT_CHECK_EN
        chk("ch1_low_kept",  104, 32'(bus.limit_low_out[5:3]),  32'd1);
        chk("ch1_high_kept", 105, 32'(bus.limit_high_out[5:3]), 32'd2);
        chk("ch1_cfg_err",   106, 32'(bus.cfg_err),             32'(4'b0010));
`else
        chk("ch1_low_load",  104, 32'(bus.limit_low_out[5:3]),  32'd5);
        chk("ch1_high_load", 105, 32'(bus.limit_high_out[5:3]), 32'd2);
        chk("ch1_cfg_err",   106, 32'(bus.cfg_err),             32'd0);
`endif
        chk("ch3_low_load",  107, 32'(bus.limit_low_out[11:9]), 32'd3);
        $display("seq limit: lo=%h hi=%h cfg_err=%b", bus.limit_low_out, bus.limit_high_out, bus.cfg_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
